// File: rtl/qsys_basic_pio_arbiter.sv
// Two-master round-robin arbiter in front of a single PIO Avalon-MM slave.
// One access in flight at a time; reads return with an explicit readdatavalid.
`timescale 1ns/1ps
module qsys_basic_pio_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_m0_address,
    input  logic              i_m0_read,
    input  logic              i_m0_write,
    input  logic [DATA_W-1:0] i_m0_writedata,
    output logic              o_m0_waitrequest,
    output logic [DATA_W-1:0] o_m0_readdata,
    output logic              o_m0_readdatavalid,
    input  logic [ADDR_W-1:0] i_m1_address,
    input  logic              i_m1_read,
    input  logic              i_m1_write,
    input  logic [DATA_W-1:0] i_m1_writedata,
    output logic              o_m1_waitrequest,
    output logic [DATA_W-1:0] o_m1_readdata,
    output logic              o_m1_readdatavalid,
    output logic [ADDR_W-1:0] o_pio_address,
    output logic              o_pio_chipselect,
    output logic              o_pio_write_n,
    output logic [DATA_W-1:0] o_pio_writedata,
    input  logic [DATA_W-1:0] i_pio_readdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDATA
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_grant;
    logic r_last_grant;
    logic r_is_write;

    logic w_req0;
    logic w_req1;
    logic w_take;
    logic w_done;
    logic w_grant_nxt;
    logic w_wr_nxt;
    logic w_issue_nxt;

    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    logic [ADDR_W-1:0] r_pio_address;
    logic [DATA_W-1:0] r_pio_writedata;
    logic              r_pio_chipselect;
    logic              r_pio_write_n;

    logic [DATA_W-1:0] r_m0_readdata;
    logic [DATA_W-1:0] r_m1_readdata;
    logic              r_m0_rvalid;
    logic              r_m1_rvalid;

    assign w_req0 = i_m0_read | i_m0_write;
    assign w_req1 = i_m1_read | i_m1_write;

    assign w_addr_sel  = w_grant_nxt ? i_m1_address : i_m0_address;
    assign w_wdata_sel = w_grant_nxt ? i_m1_writedata : i_m0_writedata;
    assign w_issue_nxt = (w_state_nxt == ISSUE);

    // Next state, round-robin choice and command type of the next access
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_done      = 1'b0;
        w_grant_nxt = r_grant;
        w_wr_nxt    = r_is_write;
        unique case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                    if (w_req0 & w_req1) begin
                        w_grant_nxt = ~r_last_grant;
                    end else begin
                        w_grant_nxt = w_req1;
                    end
                    w_wr_nxt = w_grant_nxt ? i_m1_write : i_m0_write;
                end
            end
            ISSUE: begin
                if (r_is_write) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = RDATA;
                end
            end
            RDATA: begin
                w_state_nxt = IDLE;
                w_done      = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, latched grant/type and fairness pointer
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_is_write   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_is_write <= w_wr_nxt;
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Slave-side command registers; address/data hold after the access
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pio_address    <= '0;
            r_pio_writedata  <= '0;
            r_pio_chipselect <= 1'b0;
            r_pio_write_n    <= 1'b1;
        end else begin
            r_pio_chipselect <= w_issue_nxt;
            r_pio_write_n    <= ~(w_issue_nxt & w_wr_nxt);
            if (w_take) begin
                r_pio_address   <= w_addr_sel;
                r_pio_writedata <= w_wdata_sel;
            end
        end
    end

    // Read return: capture slave data in RDATA, pulse valid the next cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_m0_readdata <= '0;
            r_m1_readdata <= '0;
            r_m0_rvalid   <= 1'b0;
            r_m1_rvalid   <= 1'b0;
        end else begin
            r_m0_rvalid <= (r_state == RDATA) & ~r_grant;
            r_m1_rvalid <= (r_state == RDATA) & r_grant;
            if ((r_state == RDATA) && !r_grant) begin
                r_m0_readdata <= i_pio_readdata;
            end
            if ((r_state == RDATA) && r_grant) begin
                r_m1_readdata <= i_pio_readdata;
            end
        end
    end

    assign o_m0_waitrequest = ~((r_state == ISSUE) & ~r_grant);
    assign o_m1_waitrequest = ~((r_state == ISSUE) & r_grant);

    assign o_m0_readdata      = r_m0_readdata;
    assign o_m1_readdata      = r_m1_readdata;
    assign o_m0_readdatavalid = r_m0_rvalid;
    assign o_m1_readdatavalid = r_m1_rvalid;

    assign o_pio_address    = r_pio_address;
    assign o_pio_writedata  = r_pio_writedata;
    assign o_pio_chipselect = r_pio_chipselect;
    assign o_pio_write_n    = r_pio_write_n;

endmodule

// File: tb/tb_qsys_basic_pio_arbiter.sv
// Bench for qsys_basic_pio_arbiter: Avalon masters with command queues,
// a PIO slave model and a timeline reference model of the arbiter.
`timescale 1ns/1ps
module tb_qsys_basic_pio_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]         m_rd = '0;
    logic [1:0]         m_wr = '0;
    logic [1:0][AW-1:0] m_adr = '0;
    logic [1:0][DW-1:0] m_wd = '0;
    logic [1:0]         wq;
    logic [1:0]         rv;
    logic [1:0][DW-1:0] rdat;

    logic [AW-1:0] padr;
    logic          cs;
    logic          wn;
    logic [DW-1:0] pwd;
    logic [DW-1:0] prd = '0;

    logic [DW-1:0] slv [8];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model: a timeline of when things must happen
    cmd_t          q [2][$];
    bit   [1:0]    acc = '0;
    int            iss_cyc = -1;
    int            iss_m = 0;
    bit            iss_wr = 0;
    int            rv_cyc [2] = '{-1, -1};
    logic [DW-1:0] rv_dat [2];
    logic [DW-1:0] exp_rd [2] = '{0, 0};
    logic [AW-1:0] exp_adr = '0;
    logic [DW-1:0] exp_wd = '0;
    logic [DW-1:0] mem [8];
    int            last = 1;
    int            free_at = 0;
    bit            rnd_on = 0;
    int            pct [2] = '{0, 0};

    always #5 clk = ~clk;

    qsys_basic_pio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_m0_address       (m_adr[0]),
        .i_m0_read          (m_rd[0]),
        .i_m0_write         (m_wr[0]),
        .i_m0_writedata     (m_wd[0]),
        .o_m0_waitrequest   (wq[0]),
        .o_m0_readdata      (rdat[0]),
        .o_m0_readdatavalid (rv[0]),
        .i_m1_address       (m_adr[1]),
        .i_m1_read          (m_rd[1]),
        .i_m1_write         (m_wr[1]),
        .i_m1_writedata     (m_wd[1]),
        .o_m1_waitrequest   (wq[1]),
        .o_m1_readdata      (rdat[1]),
        .o_m1_readdatavalid (rv[1]),
        .o_pio_address      (padr),
        .o_pio_chipselect   (cs),
        .o_pio_write_n      (wn),
        .o_pio_writedata    (pwd),
        .i_pio_readdata     (prd)
    );

    // PIO slave: registered readdata, write on chipselect & ~write_n
    always @(posedge clk) begin
        prd <= slv[padr];
        if (cs && !wn) slv[padr] <= pwd;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int k;
        k = $urandom_range(3);
        c.rd = (k != 2);
        c.wr = (k >= 2);
        c.adr = AW'($urandom);
        c.dat = $urandom;
        return c;
    endfunction

    function automatic cmd_t mk(input bit rd, input bit wr,
                                input int adr, input logic [31:0] dat);
        cmd_t c;
        c.rd = rd;
        c.wr = wr;
        c.adr = AW'(adr);
        c.dat = dat;
        return c;
    endfunction

    task automatic step(input bit do_rst);
        cmd_t c;
        bit r0, r1;
        int g;
        @(posedge clk);
        cyc++;
        #1;
        for (int m = 0; m < 2; m++)
            if (rv_cyc[m] == cyc) exp_rd[m] = rv_dat[m];
        chk("chipselect", 32'(cs), 32'(iss_cyc == cyc));
        chk("write_n", 32'(wn), 32'(!(iss_cyc == cyc && iss_wr)));
        chk("pio_addr", 32'(padr), 32'(exp_adr));
        chk("pio_wdata", pwd, exp_wd);
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "m0_waitreq" : "m1_waitreq", 32'(wq[m]),
                32'(!(iss_cyc == cyc && iss_m == m)));
            chk(m == 0 ? "m0_rvalid" : "m1_rvalid", 32'(rv[m]),
                32'(rv_cyc[m] == cyc));
            chk(m == 0 ? "m0_rdata" : "m1_rdata", rdat[m], exp_rd[m]);
        end
        if (do_rst) begin
            rst_n = 1'b0;
            for (int m = 0; m < 2; m++) begin
                q[m].delete();
                acc[m] = 1'b0;
                m_rd[m] = 1'b0;
                m_wr[m] = 1'b0;
                if (rv_cyc[m] > cyc) rv_cyc[m] = -1;
                exp_rd[m] = '0;
            end
            if (iss_cyc > cyc) iss_cyc = -1;
            exp_adr = '0;
            exp_wd = '0;
            last = 1;
            free_at = cyc + 1;
            return;
        end
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            if (acc[m]) begin
                void'(q[m].pop_front());
                acc[m] = 1'b0;
            end
            if (rnd_on && q[m].size() == 0 && $urandom_range(99) < pct[m])
                q[m].push_back(rand_cmd());
            if (q[m].size() > 0) begin
                c = q[m][0];
                m_rd[m] = c.rd;
                m_wr[m] = c.wr;
                m_adr[m] = c.adr;
                m_wd[m] = c.dat;
                if (!wq[m]) acc[m] = 1'b1;
            end else begin
                m_rd[m] = 1'b0;
                m_wr[m] = 1'b0;
                m_adr[m] = AW'($urandom);
                m_wd[m] = $urandom;
            end
        end
        if (cyc >= free_at) begin
            r0 = q[0].size() > 0;
            r1 = q[1].size() > 0;
            if (r0 || r1) begin
                g = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
                c = q[g][0];
                iss_cyc = cyc + 1;
                iss_m = g;
                iss_wr = c.wr;
                exp_adr = c.adr;
                exp_wd = c.dat;
                last = g;
                if (c.wr) begin
                    mem[c.adr] = c.dat;
                    free_at = cyc + 2;
                end else begin
                    rv_cyc[g] = cyc + 3;
                    rv_dat[g] = mem[c.adr];
                    free_at = cyc + 3;
                end
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || cyc < free_at)
               && k < 300) begin
            step(0);
            k++;
        end
        chk("drain_timeout", 32'(k >= 300), 32'(0));
    endtask

    initial begin
        int k;
        foreach (slv[i]) slv[i] = '0;
        foreach (mem[i]) mem[i] = '0;
        step(1);
        step(1);

        q[0].push_back(mk(0, 1, 0, 32'h0000_00A5));
        drain();

        q[0].push_back(mk(0, 1, 1, 32'h0000_003C));
        drain();
        q[1].push_back(mk(1, 0, 1, 32'h1234_5678));
        drain();

        for (int i = 0; i < 3; i++) begin
            q[0].push_back(mk(0, 1, i, 32'h100 + i));
            q[1].push_back(mk(0, 1, i + 4, 32'h200 + i));
        end
        drain();

        step(1);
        q[0].push_back(mk(1, 0, 1, 32'h0));
        q[1].push_back(mk(0, 1, 2, 32'hBEEF));
        drain();

        q[1].push_back(mk(1, 0, 2, 32'h0));
        k = 0;
        while (iss_cyc != cyc && k < 20) begin
            step(0);
            k++;
        end
        chk("reach_issue", 32'(k >= 20), 32'(0));
        step(1);
        step(0);
        q[0].push_back(mk(0, 1, 3, 32'hAAAA));
        q[1].push_back(mk(0, 1, 5, 32'h5555));
        drain();

        q[0].push_back(mk(1, 1, 4, 32'h0000_000F));
        drain();
        q[1].push_back(mk(1, 0, 4, 32'h0));
        drain();

        rnd_on = 1;
        for (int s = 0; s < 6; s++) begin
            pct[0] = (s == 0) ? 100 : 20 * s;
            pct[1] = (s == 0) ? 100 : 100 - 15 * s;
            for (int i = 0; i < 300; i++)
                step($urandom_range(249) == 0);
        end
        rnd_on = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsys_basic_pio_arbiter.md
# qsys_basic_pio_arbiter

Two-port round-robin arbiter that shares one PIO Avalon-MM slave (3-bit address, 32-bit data, registered readdata, no waitrequest) between two Avalon-MM masters. It sits between the Qsys fabric masters (e.g. CPU and a DMA/test sequencer) and the PIO slave. It serialises their accesses, drives the slave's chipselect/write_n strobes, and returns read data with explicit readdatavalid after the slave's fixed one-cycle read latency.

## Interface
- ADDR_W, 3, PIO register address width
- DATA_W, 32, data width on both master ports and slave port

- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  reset, synchronous, active-low
- m0_address / m1_address  in  ADDR_W  master register address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  command not yet accepted
- m0_readdata / m1_readdata  out  DATA_W  read return data
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle pulse qualifying readdata
- pio_address  out  ADDR_W  slave address
- pio_chipselect  out  1  slave select
- pio_write_n  out  1  slave write strobe, active-low
- pio_writedata  out  DATA_W  slave write data
- pio_readdata  in  DATA_W  slave readdata, valid the cycle after address is presented

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- Request for master N is (mN_read | mN_write). If both read and write are high, the access is a write.
- IDLE with no request: stay in IDLE.
- IDLE with one request: grant that master.
- IDLE with both requesting: grant the master not granted last (last_grant pointer). last_grant resets to 1, so m0 wins the first tie.
- On grant, latch the command (address, read/write, writedata, grant index) and go to ISSUE.
- ISSUE: drive the latched command onto pio_*, with pio_chipselect=1 and pio_write_n=~is_write. mN_waitrequest=0 for the granted master in this cycle only.
  - Write: return to IDLE and update last_grant.
  - Read: go to RDATA.
- RDATA: capture pio_readdata into mN_readdata of the granted master. Assert mN_readdatavalid in the next cycle. Update last_grant. Return to IDLE.
- Outside ISSUE: pio_chipselect=0, pio_write_n=1. pio_address/pio_writedata hold their last value.
- mN_waitrequest = ~(state==ISSUE && grant==N). It is high whenever not accepting, including while idle.
- The non-granted master's readdata is unchanged. Its readdatavalid stays 0.
- Masters obey Avalon hold rules (command stable while waitrequest high). The arbiter's behaviour is defined anyway because it uses only the latched command.
- Reset (reset_n=0 at a clk edge), including mid-transaction:
  - FSM returns to IDLE and any in-flight read is dropped (no readdatavalid).
  - last_grant=1.
  - Outputs: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, mN_readdata=0, mN_readdatavalid=0, mN_waitrequest=1.

## Timing
- All outputs are registered, except mN_waitrequest, which decodes the registered state and grant only (no input-to-output path).
- Write: request seen in IDLE at T0; ISSUE at T1 with waitrequest low; slave register updates at the T1/T2 edge; IDLE at T2.
- Read: request at T0; ISSUE at T1; RDATA at T2 (pio_readdata valid); readdatavalid=1 with data at T3; IDLE at T3.
- The IDLE state at T3 may grant a new request in the same cycle as readdatavalid.
- Peak throughput: one write per 2 cycles, one read per 3 cycles. No pipelining; at most one outstanding access.
- Round-robin guarantee: with both masters continuously requesting, grants strictly alternate, and neither waits more than one other access.

## Test plan
- Reset then m0 write addr 0 data 0x000000A5 -> pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata=0xA5 for exactly 1 cycle (T1); m0_waitrequest low only at T1; m1 signals untouched.
- m1 read addr 1, pio_readdata=0x0000003C during RDATA -> m1_readdatavalid pulses 1 cycle at T3 with m1_readdata=0x3C; m0_readdatavalid stays 0.
- m0 and m1 both write continuously for 6 accesses -> grant order m0,m1,m0,m1,m0,m1; each access 2 cycles; pio_write_n low every other cycle.
- m0 read and m1 write asserted same cycle after reset -> m0 read serviced first (readdatavalid at T3), m1 write ISSUE at T4.
- reset_n low for 1 cycle while in RDATA -> no readdatavalid on either port; all outputs at reset values next cycle; next tie goes to m0.
- m0_read and m0_write both high, addr 4, data 0x0F -> treated as write (pio_write_n=0); no readdatavalid.
